// File: rtl/context_stats_store_pkg.sv
// Shared types and constants for the JPEG-LS context statistics store.
// Optional feature macro: CONTEXT_STATS_NN_EN (adds the Nn counter per entry).
package context_stats_store_pkg;

    localparam int CTX_WIDTH = 9;
    localparam int NUM_CTX   = 367;
    localparam int A_WIDTH   = 16;
    localparam int B_WIDTH   = 16;
    localparam int C_WIDTH   = 8;
    localparam int N_WIDTH   = 7;
    localparam int ERR_WIDTH = 9;
    localparam int A_INIT    = 4;
    localparam int RESET_VAL = 64;
    localparam int NEAR      = 0;
    localparam int RI_CTX_EQ = 365;
    localparam int RI_CTX_NE = 366;
    localparam int C_MIN     = -128;
    localparam int C_MAX     = 127;

    // One statistics entry; B and C hold two's complement values.
    typedef struct packed {
        logic [A_WIDTH-1:0] a;
        logic [B_WIDTH-1:0] b;
        logic [C_WIDTH-1:0] c;
        logic [N_WIDTH-1:0] n;
`ifdef CONTEXT_STATS_NN_EN
        logic [N_WIDTH-1:0] nn;
`endif
    } entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Value written to every entry by the initialisation sweep.
    function automatic entry_t init_entry();
        entry_t e;
        e   = '0;
        e.a = A_WIDTH'(A_INIT);
        e.n = N_WIDTH'(1);
        return e;
    endfunction

endpackage

// File: rtl/context_stats_update.sv
// Combinational second-stage update of one context entry from its Errval.
// Optional feature macro: CONTEXT_STATS_NN_EN (Nn counter for run-interruption contexts).
module context_stats_update
    import context_stats_store_pkg::*;
(
    input  entry_t                 entry_in,
    input  logic [CTX_WIDTH-1:0]   ctx,
    input  logic [ERR_WIDTH-1:0]   err,
    output entry_t                 entry_out
);

    // B is evaluated one bit wider than stored so intermediate sums cannot wrap.
    localparam int BW = B_WIDTH + 1;
    localparam logic signed [BW-1:0]      NEAR_MUL = BW'(2 * NEAR + 1);
    localparam logic [C_WIDTH-1:0]        C_MIN_V  = C_WIDTH'(C_MIN);
    localparam logic [C_WIDTH-1:0]        C_MAX_V  = C_WIDTH'(C_MAX);

    logic                    ri;
    logic                    halve;
    logic [ERR_WIDTH-1:0]    err_abs;
    logic [A_WIDTH:0]        a_sum;
    logic [A_WIDTH-1:0]      a_v;
    logic signed [BW-1:0]    err_w;
    logic signed [BW-1:0]    b_w;
    logic signed [BW-1:0]    n_w;
    logic [C_WIDTH-1:0]      c_v;
    logic [N_WIDTH-1:0]      n_v;
`ifdef CONTEXT_STATS_NN_EN
    logic [N_WIDTH-1:0]      nn_v;
`endif

    // A/B accumulate, halve at RESET_VAL, bump N, then bias-correct B and C.
    always_comb begin
        ri      = (ctx == CTX_WIDTH'(RI_CTX_EQ)) || (ctx == CTX_WIDTH'(RI_CTX_NE));
        halve   = (entry_in.n == N_WIDTH'(RESET_VAL));
        err_abs = err[ERR_WIDTH-1] ? (~err + 1'b1) : err;
        err_w   = {{(BW-ERR_WIDTH){err[ERR_WIDTH-1]}}, err};

        a_sum = {1'b0, entry_in.a} + {{(A_WIDTH+1-ERR_WIDTH){1'b0}}, err_abs};
        a_v   = a_sum[A_WIDTH] ? '1 : a_sum[A_WIDTH-1:0];

        b_w = {entry_in.b[B_WIDTH-1], entry_in.b};
        if (!ri) begin
            b_w = b_w + err_w * NEAR_MUL;
        end

        n_v = entry_in.n;
`ifdef CONTEXT_STATS_NN_EN
        nn_v = entry_in.nn;
        if (ri && err[ERR_WIDTH-1]) begin
            nn_v = nn_v + N_WIDTH'(1);
        end
`endif
        if (halve) begin
            a_v = a_v >> 1;
            b_w = b_w >>> 1;
            n_v = n_v >> 1;
`ifdef CONTEXT_STATS_NN_EN
            nn_v = nn_v >> 1;
`endif
        end
        n_v = n_v + N_WIDTH'(1);
        n_w = {{(BW-N_WIDTH){1'b0}}, n_v};

        c_v = entry_in.c;
        if (!ri) begin
            if (b_w <= -n_w) begin
                b_w = b_w + n_w;
                if (c_v != C_MIN_V) begin
                    c_v = c_v - C_WIDTH'(1);
                end
                if (b_w <= -n_w) begin
                    b_w = -n_w + BW'(1);
                end
            end else if (!b_w[BW-1] && (b_w != '0)) begin
                b_w = b_w - n_w;
                if (c_v != C_MAX_V) begin
                    c_v = c_v + C_WIDTH'(1);
                end
                if (!b_w[BW-1] && (b_w != '0)) begin
                    b_w = '0;
                end
            end
        end

        entry_out   = entry_in;
        entry_out.a = a_v;
        entry_out.b = b_w[B_WIDTH-1:0];
        entry_out.c = c_v;
        entry_out.n = n_v;
`ifdef CONTEXT_STATS_NN_EN
        entry_out.nn = nn_v;
`endif
    end

endmodule

// File: rtl/context_stats_store.sv
// JPEG-LS per-context A/B/C/N store: init sweep, registered lookups,
// two-stage read-modify-write update with hazard forwarding.
// Optional feature macro: CONTEXT_STATS_NN_EN (adds Nn storage and rd_Nn).
//
// Handshake: a lookup transfers on a cycle where lk_valid && lk_ready; its
// result appears with rd_valid one cycle later. Updates have no back-pressure
// and are taken on any cycle with upd_valid once init_done is high.
module context_stats_store
    import context_stats_store_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    output logic                   init_done,
    input  logic                   lk_valid,
    output logic                   lk_ready,
    input  logic [CTX_WIDTH-1:0]   lk_ctx,
    output logic                   rd_valid,
    output logic [A_WIDTH-1:0]     rd_A,
    output logic [B_WIDTH-1:0]     rd_B,
    output logic [C_WIDTH-1:0]     rd_C,
    output logic [N_WIDTH-1:0]     rd_N,
`ifdef CONTEXT_STATS_NN_EN
    output logic [N_WIDTH-1:0]     rd_Nn,
`endif
    input  logic                   upd_valid,
    input  logic [CTX_WIDTH-1:0]   upd_ctx,
    input  logic [ERR_WIDTH-1:0]   upd_err,
    output state_t                 dbg_state
);

    state_t                 state_q, state_d;
    logic [CTX_WIDTH-1:0]   init_ptr_q;
    logic                   init_done_q;

    entry_t                 mem [NUM_CTX];

    logic                   upd_acc;
    logic [CTX_WIDTH-1:0]   upd_idx;
    entry_t                 upd_rd;
    logic                   u1_valid_q;
    logic [CTX_WIDTH-1:0]   u1_ctx_q;
    logic [ERR_WIDTH-1:0]   u1_err_q;
    entry_t                 u1_entry_q;
    entry_t                 u2_entry;

    logic                   lk_acc;
    logic                   lk_in_range;
    logic [CTX_WIDTH-1:0]   lk_idx;
    entry_t                 lk_data;
    logic                   rd_valid_q;
    entry_t                 rd_entry_q;

    // Next-state: sweep every entry once, then serve traffic forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_ptr_q == CTX_WIDTH'(NUM_CTX - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM state, sweep pointer and the one-edge-delayed ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_q == ST_RUN);
            if (state_q == ST_INIT) begin
                init_ptr_q <= init_ptr_q + CTX_WIDTH'(1);
            end
        end
    end

    assign init_done = init_done_q;
    assign lk_ready  = init_done_q;
    assign dbg_state = state_q;

    // Update stage 1 source: forward the entry U2 is writing this cycle.
    always_comb begin
        upd_acc = upd_valid && init_done_q && (upd_ctx < CTX_WIDTH'(NUM_CTX));
        upd_idx = (upd_ctx < CTX_WIDTH'(NUM_CTX)) ? upd_ctx : '0;
        upd_rd  = mem[upd_idx];
        if (u1_valid_q && (u1_ctx_q == upd_ctx)) begin
            upd_rd = u2_entry;
        end
    end

    // U1 registers: captured entry, context and error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u1_valid_q <= 1'b0;
            u1_ctx_q   <= '0;
            u1_err_q   <= '0;
            u1_entry_q <= '0;
        end else begin
            u1_valid_q <= upd_acc;
            if (upd_acc) begin
                u1_ctx_q   <= upd_ctx;
                u1_err_q   <= upd_err;
                u1_entry_q <= upd_rd;
            end
        end
    end

    context_stats_update u_update (
        .entry_in  (u1_entry_q),
        .ctx       (u1_ctx_q),
        .err       (u1_err_q),
        .entry_out (u2_entry)
    );

    // Storage write port: sweep writes during INIT, U2 commits during RUN.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[init_ptr_q] <= init_entry();
        end else if (u1_valid_q) begin
            mem[u1_ctx_q] <= u2_entry;
        end
    end

    // Lookup source: zeros out of range, U2 result on a same-context write.
    always_comb begin
        lk_acc      = lk_valid && init_done_q;
        lk_in_range = (lk_ctx < CTX_WIDTH'(NUM_CTX));
        lk_idx      = lk_in_range ? lk_ctx : '0;
        lk_data     = mem[lk_idx];
        if (!lk_in_range) begin
            lk_data = '0;
        end else if (u1_valid_q && (u1_ctx_q == lk_ctx)) begin
            lk_data = u2_entry;
        end
    end

    // Registered lookup result; data holds while no lookup is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            rd_valid_q <= lk_acc;
            if (lk_acc) begin
                rd_entry_q <= lk_data;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_A     = rd_entry_q.a;
    assign rd_B     = rd_entry_q.b;
    assign rd_C     = rd_entry_q.c;
    assign rd_N     = rd_entry_q.n;
`ifdef CONTEXT_STATS_NN_EN
    assign rd_Nn    = rd_entry_q.nn;
`endif

endmodule

// File: tb/tb_context_stats_store.sv
// Bench for context_stats_store: directed cases plus randomized traffic
// against a behavioural per-context model.
module tb_context_stats_store;
    import context_stats_store_pkg::*;

    localparam int EW = A_WIDTH + B_WIDTH + C_WIDTH + N_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 init_done;
    logic                 lk_valid = 1'b0;
    logic                 lk_ready;
    logic [CTX_WIDTH-1:0] lk_ctx = '0;
    logic                 rd_valid;
    logic [A_WIDTH-1:0]   rd_A;
    logic [B_WIDTH-1:0]   rd_B;
    logic [C_WIDTH-1:0]   rd_C;
    logic [N_WIDTH-1:0]   rd_N;
`ifdef CONTEXT_STATS_NN_EN
    logic [N_WIDTH-1:0]   rd_Nn;
`endif
    logic                 upd_valid = 1'b0;
    logic [CTX_WIDTH-1:0] upd_ctx = '0;
    logic [ERR_WIDTH-1:0] upd_err = '0;
    state_t               dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // reference model: one integer per statistic per context
    int m_a [NUM_CTX];
    int m_b [NUM_CTX];
    int m_c [NUM_CTX];
    int m_n [NUM_CTX];

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_rd;

    context_stats_store dut (
        .clk       (clk),
        .reset     (reset),
        .init_done (init_done),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_ctx    (lk_ctx),
        .rd_valid  (rd_valid),
        .rd_A      (rd_A),
        .rd_B      (rd_B),
        .rd_C      (rd_C),
        .rd_N      (rd_N),
`ifdef CONTEXT_STATS_NN_EN
        .rd_Nn     (rd_Nn),
`endif
        .upd_valid (upd_valid),
        .upd_ctx   (upd_ctx),
        .upd_err   (upd_err),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < NUM_CTX; i++) begin
            m_a[i] = A_INIT;
            m_b[i] = 0;
            m_c[i] = 0;
            m_n[i] = 1;
        end
    endfunction

    function automatic logic [EW-1:0] model_pack(input int ctx);
        logic [A_WIDTH-1:0] a;
        logic [B_WIDTH-1:0] b;
        logic [C_WIDTH-1:0] c;
        logic [N_WIDTH-1:0] n;
        if (ctx >= NUM_CTX) return '0;
        a = A_WIDTH'(m_a[ctx]);
        b = B_WIDTH'(m_b[ctx]);
        c = C_WIDTH'(m_c[ctx]);
        n = N_WIDTH'(m_n[ctx]);
        return {a, b, c, n};
    endfunction

    // JPEG-LS statistics update in plain integer arithmetic
    function automatic void model_upd(input int ctx, input int err);
        int a, b, c, n;
        bit ri;
        if (ctx >= NUM_CTX) return;
        ri = (ctx == RI_CTX_EQ) || (ctx == RI_CTX_NE);
        a = m_a[ctx] + ((err < 0) ? -err : err);
        if (a > 65535) a = 65535;
        b = m_b[ctx];
        c = m_c[ctx];
        n = m_n[ctx];
        if (!ri) b = b + err * (2 * NEAR + 1);
        if (n == RESET_VAL) begin
            a = a / 2;
            b = b >>> 1;
            n = n / 2;
        end
        n = n + 1;
        if (!ri) begin
            if (b <= -n) begin
                b = b + n;
                if (c > C_MIN) c = c - 1;
                if (b <= -n) b = -n + 1;
            end else if (b > 0) begin
                b = b - n;
                if (c < C_MAX) c = c + 1;
                if (b > 0) b = 0;
            end
        end
        m_a[ctx] = a;
        m_b[ctx] = b;
        m_c[ctx] = c;
        m_n[ctx] = n;
    endfunction

    // one clock of traffic; entered and left at the falling edge
    task automatic drive_cycle(input bit lv, input int lc, input bit uv, input int uc, input int ue);
        logic [EW-1:0] e;
        lk_valid  = lv;
        lk_ctx    = CTX_WIDTH'(lc);
        upd_valid = uv;
        upd_ctx   = CTX_WIDTH'(uc);
        upd_err   = ERR_WIDTH'(ue);
        if (lv) exp_q.push_back(model_pack(lc));
        if (uv) model_upd(uc, ue);
        @(posedge clk);
        #1;
        if (lv) begin
            check_eq("rd_valid", 64'(rd_valid), 64'd1);
            e = exp_q.pop_front();
            last_rd = e;
            check_eq($sformatf("rd_entry ctx %0d", lc), 64'({rd_A, rd_B, rd_C, rd_N}), 64'(e));
        end else begin
            check_eq("rd_valid_idle", 64'(rd_valid), 64'd0);
            check_eq("rd_hold", 64'({rd_A, rd_B, rd_C, rd_N}), 64'(last_rd));
        end
        @(negedge clk);
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
    endtask

    // release reset (caller holds it high) and time the sweep
    task automatic release_and_sweep(input bit poke_upd);
        int cnt;
        @(negedge clk);
        reset = 1'b0;
        upd_valid = poke_upd;
        upd_ctx   = CTX_WIDTH'(5);
        upd_err   = ERR_WIDTH'(100);
        cnt = 0;
        while (!init_done && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 367) check_eq("lk_ready_low_late", 64'(lk_ready), 64'd0);
        end
        upd_valid = 1'b0;
        check_eq("init_cycles", 64'(cnt), 64'd368);
        check_eq("lk_ready_up", 64'(lk_ready), 64'd1);
        check_eq("state_run", 64'(dbg_state), 64'(ST_RUN));
        model_init();
        exp_q.delete();
        last_rd = '0;
        @(negedge clk);
    endtask

    function automatic int pick_ctx();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 4) return 10 + r;
        if (r == 5) return RI_CTX_EQ;
        if (r == 6) return RI_CTX_NE;
        if (r == 7) return NUM_CTX + int'($urandom_range(0, 144));
        return int'($urandom_range(0, NUM_CTX - 1));
    endfunction

    initial begin
        last_rd = '0;
        model_init();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_init_done", 64'(init_done), 64'd0);
        check_eq("rst_lk_ready", 64'(lk_ready), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_rd_data", 64'({rd_A, rd_B, rd_C, rd_N}), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'(ST_INIT));
        release_and_sweep(1'b0);

        // swept entries and out-of-range lookups
        drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(1, 200, 0, 0, 0);
        drive_cycle(1, 366, 0, 0, 0);
        check_eq("init_A_366", 64'(rd_A), 64'd4);
        check_eq("init_N_366", 64'(rd_N), 64'd1);
        drive_cycle(1, 367, 0, 0, 0);
        drive_cycle(1, 511, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);

        // single update, err=+5
        drive_cycle(0, 0, 1, 10, 5);
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(1, 10, 0, 0, 0);
        check_eq("ctx10_A", 64'(rd_A), 64'd9);
        check_eq("ctx10_B", 64'(rd_B), 64'd0);
        check_eq("ctx10_C", 64'(rd_C), 64'd1);
        check_eq("ctx10_N", 64'(rd_N), 64'd2);

        // back-to-back same context
        drive_cycle(0, 0, 1, 10, -3);
        drive_cycle(0, 0, 1, 10, -3);
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(1, 10, 0, 0, 0);
        check_eq("b2b_A", 64'(rd_A), 64'd15);
        check_eq("b2b_N", 64'(rd_N), 64'd4);

        // 64 zero-error updates: halving at N==64 leaves N=33, A=2
        for (int i = 0; i < 64; i++) drive_cycle(0, 0, 1, 20, 0);
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(1, 20, 0, 0, 0);
        check_eq("halve_A", 64'(rd_A), 64'd2);
        check_eq("halve_N", 64'(rd_N), 64'd33);

        // lookup during U2 write, lookup during U1, and unrelated context
        drive_cycle(0, 0, 1, 50, 7);
        drive_cycle(1, 50, 1, 50, -9);
        drive_cycle(1, 50, 1, 50, 2);
        drive_cycle(1, 51, 0, 0, 0);
        drive_cycle(1, 50, 0, 0, 0);

        // run-interruption contexts and dropped out-of-range update
        drive_cycle(0, 0, 1, RI_CTX_EQ, -5);
        drive_cycle(0, 0, 1, RI_CTX_NE, 40);
        drive_cycle(1, RI_CTX_EQ, 1, 400, 50);
        drive_cycle(1, RI_CTX_NE, 0, 0, 0);
        drive_cycle(1, 400, 0, 0, 0);

        // randomized mixed traffic
        for (int i = 0; i < 2000; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), pick_ctx(),
                        1'($urandom_range(0, 3) != 0), pick_ctx(),
                        int'($urandom_range(0, 511)) - 256);
        end

        // reset in the middle of an update stream
        drive_cycle(1, 10, 1, 11, 30);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("midrst_init_done", 64'(init_done), 64'd0);
        check_eq("midrst_state", 64'(dbg_state), 64'(ST_INIT));
        repeat (2) @(posedge clk);
        release_and_sweep(1'b1);
        drive_cycle(1, 5, 0, 0, 0);
        drive_cycle(1, 10, 0, 0, 0);
        drive_cycle(1, 20, 0, 0, 0);
        drive_cycle(1, 50, 0, 0, 0);
        drive_cycle(1, RI_CTX_EQ, 0, 0, 0);
        check_eq("post_rst_A", 64'(rd_A), 64'd4);
        check_eq("post_rst_N", 64'(rd_N), 64'd1);
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), pick_ctx(),
                        1'($urandom_range(0, 1)), pick_ctx(),
                        int'($urandom_range(0, 511)) - 256);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
